// File: rtl/switch_debounce_pkg.sv
// Shared definitions for the switch debouncer: FSM state encodings and reset constants.
package switch_debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE_LO = 2'd0,
    ST_WAIT_HI = 2'd1,
    ST_IDLE_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } state_e;

  localparam logic UP_DN_RST = 1'b1;

endpackage : switch_debounce_pkg

// File: rtl/switch_debounce_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; synchronous active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      q_q  <= 1'b0;
    end else begin
      s1_q <= d;
      q_q  <= s1_q;
    end
  end

  assign q = q_q;

endmodule : sync_2ff

// File: rtl/switch_debounce.sv
// Debounces a raw switch: synchronise, require a stable run before accepting a new level,
// then emit level, one-cycle rise/fall pulses and a direction bit that flips on each press.
//
//  state      | meaning
//  -----------+-------------------------------------------------
//  ST_IDLE_LO | level 0 accepted, waiting for the switch to go high
//  ST_WAIT_HI | switch high, counting stable samples before committing level 1
//  ST_IDLE_HI | level 1 accepted, waiting for the switch to go low
//  ST_WAIT_LO | switch low, counting stable samples before committing level 0
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned CNT_WIDTH       = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic up_dn
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sw_s;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic                 up_dn_q, up_dn_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sw_in),
    .q   (sw_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      up_dn_q <= UP_DN_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      up_dn_q <= up_dn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    up_dn_d = up_dn_q;

    case (state_q)
      ST_IDLE_LO: begin
        if (sw_s) begin
          state_d = ST_WAIT_HI;
          cnt_d   = '0;
        end
      end
      ST_WAIT_HI: begin
        if (!sw_s) begin
          state_d = ST_IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
          up_dn_d = ~up_dn_q;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_IDLE_HI: begin
        if (!sw_s) begin
          state_d = ST_WAIT_LO;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LO: begin
        // Release commits only clear the level; direction changes on presses alone.
        if (sw_s) begin
          state_d = ST_IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign up_dn = up_dn_q;

endmodule : switch_debounce

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce at DEBOUNCE_CYCLES=4: directed scenarios plus a randomized run
// against a run-length reference model, with an up/down counter chained off up_dn.
module tb_switch_debounce;

  localparam int DC = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst;
  logic sw_in;
  logic level, rise, fall, up_dn;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  switch_debounce #(.DEBOUNCE_CYCLES(DC), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .sw_in (sw_in),
    .level (level),
    .rise  (rise),
    .fall  (fall),
    .up_dn (up_dn)
  );

  // Downstream counter: moves one step per debounced edge in the direction up_dn selects.
  logic [7:0] cnt8;
  always_ff @(posedge clk) begin
    if (rst) cnt8 <= 8'd0;
    else if (rise | fall) cnt8 <= up_dn ? cnt8 + 8'd1 : cnt8 - 8'd1;
  end

  // Reference model: sw_in delayed two samples; a level is accepted once the delayed input
  // has differed from the current level for DC+1 consecutive samples.
  logic       s1_m = 1'b0, ss_m = 1'b0;
  logic       lvl_m = 1'b0, rise_m = 1'b0, fall_m = 1'b0, updn_m = 1'b1;
  int         run_m = 0;
  logic [7:0] cnt8_m = 8'd0;

  task automatic tick();
    logic smp;
    @(posedge clk);
    if (rst) begin
      s1_m = 0; ss_m = 0; run_m = 0; lvl_m = 0; rise_m = 0; fall_m = 0; updn_m = 1;
      cnt8_m = 0;
    end else begin
      if (rise_m | fall_m) cnt8_m = updn_m ? cnt8_m + 8'd1 : cnt8_m - 8'd1;
      smp  = ss_m;
      ss_m = s1_m;
      s1_m = sw_in;
      rise_m = 0;
      fall_m = 0;
      if (smp == lvl_m) run_m = 0;
      else begin
        run_m++;
        if (run_m == DC + 1) begin
          lvl_m  = smp;
          run_m  = 0;
          rise_m = smp;
          fall_m = !smp;
          if (smp) updn_m = !updn_m;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; sw_in = 0;
    tick(); tick();
    checks++;
    if ({level, rise, fall, up_dn} !== 4'b0001) begin
      errors++; $display("FAIL reset_values got %b want 0001", {level, rise, fall, up_dn});
    end
    @(negedge clk); rst = 0;
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if ({level, rise, fall, up_dn} !== 4'b0001) begin
      errors++; $display("FAIL reset_hold got %b want 0001", {level, rise, fall, up_dn});
    end
  endtask

  // Drives a new held level and measures edges until level follows, plus pulse counts.
  task automatic drive_held(input logic val, output int lat, output int rises, output int falls);
    lat = -1; rises = 0; falls = 0;
    @(negedge clk); sw_in = val;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (level === val && lat < 0) lat = k;
      if (rise) rises++;
      if (fall) falls++;
      checks++;
      if ({level, rise, fall, up_dn} !== {lvl_m, rise_m, fall_m, updn_m}) begin
        errors++;
        $display("FAIL held_model got %b want %b", {level, rise, fall, up_dn},
                 {lvl_m, rise_m, fall_m, updn_m});
      end
    end
  endtask

  task automatic test_clean_press();
    int lat, r, f;
    drive_held(1'b1, lat, r, f);
    checks++; if (lat !== 7) begin errors++; $display("FAIL press_latency got %0d want 7", lat); end
    checks++; if (r !== 1) begin errors++; $display("FAIL press_rise_count got %0d want 1", r); end
    checks++; if (up_dn !== 1'b0) begin errors++; $display("FAIL press_up_dn got %b want 0", up_dn); end
  endtask

  task automatic test_release();
    int lat, r, f;
    drive_held(1'b0, lat, r, f);
    checks++; if (lat !== 7) begin errors++; $display("FAIL release_latency got %0d want 7", lat); end
    checks++; if (f !== 1 || r !== 0) begin
      errors++; $display("FAIL release_pulses got fall=%0d rise=%0d want 1/0", f, r);
    end
    checks++; if (up_dn !== 1'b0) begin errors++; $display("FAIL release_up_dn got %b want 0", up_dn); end
  endtask

  task automatic test_bounce();
    logic [15:0] pat;
    int hi_seen, r;
    pat = 16'b0000_0000_0111_0111;
    hi_seen = 0; r = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); sw_in = pat[i];
      tick();
      if (level) hi_seen++;
      if (rise) r++;
    end
    checks++; if (hi_seen !== 0) begin errors++; $display("FAIL bounce_level got %0d high cycles want 0", hi_seen); end
    checks++; if (r !== 0) begin errors++; $display("FAIL bounce_rise got %0d want 0", r); end
    checks++; if (up_dn !== 1'b0) begin errors++; $display("FAIL bounce_up_dn got %b want 0", up_dn); end
  endtask

  task automatic test_second_press();
    int lat, r, f;
    drive_held(1'b1, lat, r, f);
    checks++; if (up_dn !== 1'b1 || level !== 1'b1) begin
      errors++; $display("FAIL second_press got level=%b up_dn=%b want 1/1", level, up_dn);
    end
  endtask

  task automatic test_reset_mid_wait();
    int lat, r, f;
    drive_held(1'b0, lat, r, f);
    drive_held(1'b1, lat, r, f);
    drive_held(1'b0, lat, r, f);
    @(negedge clk); sw_in = 1;
    for (int k = 0; k < 5; k++) tick();
    @(negedge clk); rst = 1;
    tick();
    checks++;
    if ({level, rise, fall, up_dn} !== 4'b0001) begin
      errors++; $display("FAIL midwait_reset got %b want 0001", {level, rise, fall, up_dn});
    end
    @(negedge clk); rst = 0;
    lat = -1; r = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (level && lat < 0) lat = k;
      if (rise) r++;
    end
    checks++; if (lat !== 7) begin errors++; $display("FAIL midwait_relatch got %0d want 7", lat); end
    checks++; if (r !== 1 || up_dn !== 1'b0) begin
      errors++; $display("FAIL midwait_rise got rise=%0d up_dn=%b want 1/0", r, up_dn);
    end
  endtask

  task automatic test_random_chain();
    int left;
    left = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      if (left == 0) begin
        sw_in = $urandom_range(0, 1);
        left  = $urandom_range(1, 9);
      end
      left--;
      tick();
      checks++;
      if ({level, rise, fall, up_dn} !== {lvl_m, rise_m, fall_m, updn_m} || (rise && fall)) begin
        errors++;
        if (errors < 20)
          $display("FAIL random_model n=%0d got %b want %b", n, {level, rise, fall, up_dn},
                   {lvl_m, rise_m, fall_m, updn_m});
      end
    end
    @(negedge clk); rst = 0;
    tick();
    checks++;
    if (cnt8 !== cnt8_m) begin
      errors++; $display("FAIL chain_count got %0d want %0d", cnt8, cnt8_m);
    end
  endtask

  initial begin
    rst = 1; sw_in = 0;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_second_press();
    test_reset_mid_wait();
    test_random_chain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_switch_debounce
